// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared FSM encoding, Newton-Raphson seed constants and IEEE-754 special-value builders
package fp_div_pkg;
    typedef enum logic [2:0] {IDLE, SEED, MUL_DX, MUL_X2, MUL_Q, NORM, DONE} state_e;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} sp_e;

    localparam int FL_INV = 3;
    localparam int FL_DBZ = 2;
    localparam int FL_OVF = 1;
    localparam int FL_UNF = 0;

    // Round-to-nearest fixed-point constants with fw fractional bits.
    function automatic logic [63:0] seed_c48(input int fw);
        return ((64'd48 << fw) + 64'd8) / 64'd17;
    endfunction

    function automatic logic [63:0] seed_c32(input int fw);
        return ((64'd32 << fw) + 64'd8) / 64'd17;
    endfunction

    function automatic logic [63:0] fp_build(input sp_e k, input logic s, input int ew, input int mw);
        return (64'(s) << (ew + mw))
             | (k == SP_ZERO ? 64'd0 : ((64'd1 << ew) - 64'd1) << mw)
             | (k == SP_NAN ? 64'd1 << (mw - 1) : 64'd0);
    endfunction
endpackage

// File: rtl/fx_umul.sv
// fx_umul: unsigned fixed-point multiplier, FW fractional bits, one registered truncating stage
module fx_umul #(
    parameter int W  = 29,
    parameter int FW = 27
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_p
);
    localparam int PW = 2 * W;
    logic [PW-1:0] w_prod;
    assign w_prod = PW'(i_a) * PW'(i_b);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) o_p <= '0;
        else          o_p <= W'(w_prod >> FW);
endmodule

// File: rtl/fp_nr_divider_seq.sv
// fp_nr_divider_seq: sequential FP divider, reciprocal of B by Newton-Raphson on one shared multiplier,
// valid/ready handshake, fixed latency, special-case handling and exception flags
module fp_nr_divider_seq import fp_div_pkg::*; #(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int NR_ITERS = 3,
    parameter int GUARD_W  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   A,
    input  logic [EXP_W+MAN_W:0]   B,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);
    localparam int FP_W = 1 + EXP_W + MAN_W;
    localparam int FW   = MAN_W + GUARD_W;
    localparam int W    = FW + 2;
    localparam int EW2  = EXP_W + 2;
    localparam int IT_W = $clog2(NR_ITERS + 1);
    localparam logic [W-1:0]   C48    = W'(seed_c48(FW));
    localparam logic [W-1:0]   C32    = W'(seed_c32(FW));
    localparam logic [W-1:0]   TWO    = W'(2) << FW;
    localparam logic [W-1:0]   Q_BIAS = W'(1) << (GUARD_W >= 2 ? GUARD_W - 2 : 0);
    localparam logic [EW2-1:0] BIAS   = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW2-1:0] E_MAX  = EW2'((1 << EXP_W) - 1);

    state_e          r_state;
    sp_e             r_spec;
    logic [FP_W-1:0] r_a, r_b;
    logic [W-1:0]    r_x;
    logic [IT_W-1:0] r_it;
    logic [3:0]      r_sflags;

    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic             w_s, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_nan, w_q_ge1, w_ovf, w_unf;
    logic [W-1:0]     w_d, w_ahalf, w_p, w_x_cur, w_op_a, w_op_b, w_q, w_qn;
    logic [MAN_W-1:0] w_man;
    logic [EW2-1:0]   w_e;
    logic [63:0]      w_spec64;
    logic [FP_W-1:0]  w_res;
    logic [3:0]       w_sflags, w_flags;
    sp_e              w_kind, w_fkind;

    assign w_s      = r_a[FP_W-1] ^ r_b[FP_W-1];
    assign w_ea     = r_a[FP_W-2 -: EXP_W];
    assign w_eb     = r_b[FP_W-2 -: EXP_W];
    assign w_ma     = r_a[MAN_W-1:0];
    assign w_mb     = r_b[MAN_W-1:0];
    assign w_a_zero = ~|w_ea;
    assign w_b_zero = ~|w_eb;
    assign w_a_inf  = &w_ea && ~|w_ma;
    assign w_b_inf  = &w_eb && ~|w_mb;
    assign w_nan    = (&w_ea && |w_ma) || (&w_eb && |w_mb) || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
    assign w_kind   = w_nan ? SP_NAN : w_a_inf ? SP_INF : w_b_inf ? SP_ZERO : w_b_zero ? SP_INF : w_a_zero ? SP_ZERO : SP_NONE;

    always_comb begin
        w_sflags         = '0;
        w_sflags[FL_INV] = w_nan;
        w_sflags[FL_DBZ] = !w_nan && !w_a_inf && !w_b_inf && w_b_zero;
    end

    // {1,m}/2 in [0.5,1): the hidden bit lands on the first fractional bit.
    assign w_d     = W'({1'b1, w_mb}) << (GUARD_W - 1);
    assign w_ahalf = W'({1'b1, w_ma}) << (GUARD_W - 1);
    assign w_x_cur = (r_it == '0) ? C48 - w_p : w_p;
    assign w_op_a  = r_state == SEED ? C32 : r_state == MUL_DX ? w_d : r_state == MUL_X2 ? r_x : w_ahalf;
    assign w_op_b  = r_state == SEED ? w_d : r_state == MUL_DX ? w_x_cur : r_state == MUL_X2 ? TWO - w_p : w_p;

    fx_umul #(.W(W), .FW(FW)) u_mul (
        .clk    (clk),
        .reset_n(reset_n),
        .i_a    (w_op_a),
        .i_b    (w_op_b),
        .o_p    (w_p)
    );

    // Truncated NR products approach the quotient from below; a sub-ulp bias keeps exact quotients exact.
    assign w_q      = w_p + Q_BIAS;
    assign w_q_ge1  = |w_q[W-1:FW];
    assign w_qn     = w_q_ge1 ? w_q : w_q << 1;
    assign w_man    = MAN_W'(w_qn >> GUARD_W);
    assign w_e      = EW2'(w_ea) + BIAS - EW2'(w_eb) - EW2'(!w_q_ge1);
    assign w_ovf    = !w_e[EW2-1] && w_e >= E_MAX;
    assign w_unf    = w_e[EW2-1] || w_e == '0;
    assign w_fkind  = r_spec != SP_NONE ? r_spec : w_ovf ? SP_INF : w_unf ? SP_ZERO : SP_NONE;
    assign w_spec64 = fp_build(w_fkind, w_s, EXP_W, MAN_W);
    assign w_res    = w_fkind == SP_NONE ? {w_s, w_e[EXP_W-1:0], w_man} : FP_W'(w_spec64);

    always_comb begin
        w_flags         = r_sflags;
        w_flags[FL_OVF] = r_sflags[FL_OVF] | (r_spec == SP_NONE && w_ovf);
        w_flags[FL_UNF] = r_sflags[FL_UNF] | (r_spec == SP_NONE && !w_ovf && w_unf);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_spec    <= SP_NONE;
            r_a       <= '0;
            r_b       <= '0;
            r_x       <= '0;
            r_it      <= '0;
            r_sflags  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a      <= A;
                    r_b      <= B;
                    flags    <= '0;
                    in_ready <= 1'b0;
                    r_state  <= SEED;
                end
                SEED: begin
                    r_spec   <= w_kind;
                    r_sflags <= w_sflags;
                    r_it     <= '0;
                    r_state  <= MUL_DX;
                end
                MUL_DX: begin
                    r_x     <= w_x_cur;
                    r_state <= MUL_X2;
                end
                MUL_X2: begin
                    r_it    <= r_it + 1'b1;
                    r_state <= r_it == IT_W'(NR_ITERS - 1) ? MUL_Q : MUL_DX;
                end
                MUL_Q: r_state <= NORM;
                NORM: begin
                    result    <= w_res;
                    flags     <= w_flags;
                    out_valid <= 1'b1;
                    r_state   <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_nr_divider_seq.sv
// tb_fp_nr_divider_seq: directed and random checks of fp_nr_divider_seq against an exact-division model
module tb_fp_nr_divider_seq;
    localparam int NR_ITERS = 3;
    localparam int LAT      = 2 * NR_ITERS + 4;

    logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] A = '0, B = '0, result;
    logic [3:0]  flags;
    int          n_tests = 0, n_fail = 0;

    fp_nr_divider_seq #(.EXP_W(8), .MAN_W(23), .NR_ITERS(NR_ITERS), .GUARD_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected {flags, result} from IEEE classification and exact integer division of the significands.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        logic   s, an, bn, ai, bi, az, bz;
        int     e;
        longint ma, mb, q;
        s  = a[31] ^ b[31];
        an = a[30:23] == 8'hFF && a[22:0] != 0;
        bn = b[30:23] == 8'hFF && b[22:0] != 0;
        ai = a[30:23] == 8'hFF && a[22:0] == 0;
        bi = b[30:23] == 8'hFF && b[22:0] == 0;
        az = a[30:23] == 0;
        bz = b[30:23] == 0;
        if (an || bn || (az && bz) || (ai && bi)) return {4'b1000, s, 8'hFF, 1'b1, 22'd0};
        if (ai) return {4'b0000, s, 8'hFF, 23'd0};
        if (bi) return {4'b0000, s, 31'd0};
        if (bz) return {4'b0100, s, 8'hFF, 23'd0};
        if (az) return {4'b0000, s, 31'd0};
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        e  = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (ma >= mb) q = (ma << 23) / mb;
        else begin
            q = (ma << 24) / mb;
            e--;
        end
        if (e >= 255) return {4'b0010, s, 8'hFF, 23'd0};
        if (e <= 0) return {4'b0001, s, 31'd0};
        return {4'b0000, s, 8'(e), q[22:0]};
    endfunction

    // cyc = 1 in the cycle after the accept edge; returns the cycle in which out_valid is first seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [35:0] got, output int cyc);
        int g = 0;
        while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 4 * LAT) begin @(posedge clk); #1; cyc++; end
        got = {flags, result};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [35:0] got, exp, snap;
        logic [31:0] a, b;
        int          cyc, diff;
        logic        ok;
        #1;
        check("reset_state", 36'({in_ready, out_valid, flags, result}), 36'({1'b1, 1'b0, 4'h0, 32'h0}));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        run_op(32'h40C00000, 32'h40000000, got, cyc);
        check("6div2", got, {4'h0, 32'h40400000});
        check_int("lat_6div2", cyc, LAT);
        check("in_ready_after_hs", 36'(in_ready), 36'(1));

        run_op(32'h3F800000, 32'h40400000, got, cyc);
        check("1div3", 36'(got == {4'h0, 32'h3EAAAAAA} || got == {4'h0, 32'h3EAAAAAB}), 36'(1));

        run_op(32'h3F800000, 32'h00000000, got, cyc);
        check("1div0", got, {4'b0100, 32'h7F800000});
        check_int("lat_special", cyc, LAT);
        run_op(32'h00000000, 32'h00000000, got, cyc);
        check("0div0", got, {4'b1000, 32'h7FC00000});
        run_op(32'hC0000000, 32'h7F800000, got, cyc);
        check("m2divinf", got, {4'b0000, 32'h80000000});
        run_op(32'h7F000000, 32'h3E800000, got, cyc);
        check("overflow", got, {4'b0010, 32'h7F800000});
        check_int("lat_overflow", cyc, LAT);
        run_op(32'h00800000, 32'h41000000, got, cyc);
        check("underflow", got, {4'b0001, 32'h00000000});

        run_op(32'h7F800000, 32'hFF800000, got, cyc);
        check("infdivinf", got, model(32'h7F800000, 32'hFF800000));
        run_op(32'h7FC12345, 32'h3F800000, got, cyc);
        check("nan_op", got, model(32'h7FC12345, 32'h3F800000));
        run_op(32'h7F800000, 32'hC0000000, got, cyc);
        check("infdivm2", got, model(32'h7F800000, 32'hC0000000));
        run_op(32'hBF800000, 32'h80000000, got, cyc);
        check("m1divm0", got, model(32'hBF800000, 32'h80000000));
        run_op(32'h00400000, 32'hBF800000, got, cyc);
        check("subnormal_flush", got, model(32'h00400000, 32'hBF800000));

        A = 32'h40C00000; B = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        A = 32'h3F800000; B = 32'h40400000;
        cyc = 1;
        while (!out_valid && cyc < 4 * LAT) begin @(posedge clk); #1; cyc++; end
        check_int("lat_hold", cyc, LAT);
        snap = {flags, result};
        check("hold_first", snap, {4'h0, 32'h40400000});
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold_stable", 36'({out_valid, in_ready, flags, result}), 36'({2'b10, snap}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hs_no_accept", 36'({in_ready, out_valid}), 36'(2'b10));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("accept_after_hs", 36'(in_ready), 36'(0));
        cyc = 1;
        while (!out_valid && cyc < 4 * LAT) begin @(posedge clk); #1; cyc++; end
        check_int("lat_second", cyc, LAT);
        check("second_op", 36'({flags, result} == {4'h0, 32'h3EAAAAAA} || {flags, result} == {4'h0, 32'h3EAAAAAB}), 36'(1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        A = 32'h40C00000; B = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check("reset_mid", 36'({in_ready, out_valid, flags}), 36'({2'b10, 4'h0}));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (LAT + 2) @(posedge clk);
        #1 check("reset_discard", 36'({in_ready, out_valid}), 36'(2'b10));
        run_op(32'h40C00000, 32'h40000000, got, cyc);
        check("6div2_after_reset", got, {4'h0, 32'h40400000});
        check_int("lat_after_reset", cyc, LAT);

        for (int i = 0; i < 2000; i++) begin
            a = {1'($urandom), 8'($urandom_range(180, 70)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(180, 70)), 23'($urandom)};
            run_op(a, b, got, cyc);
            exp  = model(a, b);
            diff = int'(got[30:0]) - int'(exp[30:0]);
            ok   = cyc == LAT && got[35:31] === exp[35:31] && diff >= -1 && diff <= 1;
            n_tests++;
            assert (ok === 1'b1) else begin
                n_fail++;
                $error("FAIL random %h/%h: got %h lat %0d expected %h (+-1 ulp) lat %0d", a, b, got, cyc, exp, LAT);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
